// File: rtl/vliw_sequencer.sv
// VLIW bundle sequencer: fetches a bundle, strobes the bundle register,
// reads the decoded fields back, issues ALU slots over valid/ready and
// chooses the next PC from the next field or from a meta jump operand.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; pc holds the last loaded/stopped address
// S_FETCH  | one cycle, imem_req high with imem_addr = pc
// S_WAIT   | waiting for the first imem_valid after the request
// S_DECODE | one cycle; stop / halt / jump / empty / issue decision
// S_ISSUE  | presenting slot_idx to the ALU until the last slot handshakes
// S_HALT   | terminal after a meta bundle with eval_len 0; only reset leaves
module vliw_sequencer #(
   parameter int PC_W  = 16,
   parameter int LEN_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [PC_W-1:0]  start_pc,
   input  logic             stop,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic             imem_valid,
   output logic             ins_load,
   input  logic             dec_meta,
   input  logic [LEN_W-1:0] dec_eval_len,
   input  logic [PC_W-1:0]  dec_operand,
   input  logic [PC_W-1:0]  dec_next,
   output logic [LEN_W-1:0] slot_idx,
   output logic             alu_issue,
   input  logic             alu_ready,
   output logic             busy,
   output logic             halted,
   output logic [PC_W-1:0]  pc,
   output logic [15:0]      retired
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_ISSUE, S_HALT
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [PC_W-1:0]  r_pc, w_pc_nxt;
   logic [LEN_W-1:0] r_slot_idx, w_slot_nxt;
   logic [15:0]      r_retired, w_retired_nxt;
   logic             r_imem_req, r_ins_load, r_alu_issue;
   logic             w_len_zero, w_hs, w_last_hs, w_retire;

   assign w_len_zero = (dec_eval_len == '0);
   assign w_hs       = (r_state == S_ISSUE) && r_alu_issue && alu_ready;
   assign w_last_hs  = w_hs && (r_slot_idx == dec_eval_len - LEN_W'(1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decision
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (start) w_state_nxt = S_FETCH;
         S_FETCH:  w_state_nxt = S_WAIT;
         S_WAIT:   if (imem_valid) w_state_nxt = S_DECODE;
         S_DECODE: begin
            if (stop)                        w_state_nxt = S_IDLE;
            else if (dec_meta && w_len_zero) w_state_nxt = S_HALT;
            else if (dec_meta || w_len_zero) w_state_nxt = S_FETCH;
            else                             w_state_nxt = S_ISSUE;
         end
         S_ISSUE:  if (w_last_hs) w_state_nxt = S_FETCH;
         S_HALT:   w_state_nxt = S_HALT;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath next values: pc selection, slot stepping, retire counting
   always_comb begin
      w_pc_nxt   = r_pc;
      w_slot_nxt = r_slot_idx;
      w_retire   = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_pc_nxt = start_pc;
         S_DECODE: begin
            if (!stop) begin
               if (dec_meta && !w_len_zero) begin
                  w_pc_nxt = dec_operand;
                  w_retire = 1'b1;
               end else if (!dec_meta && w_len_zero) begin
                  w_pc_nxt = dec_next;
                  w_retire = 1'b1;
               end else if (!dec_meta) begin
                  w_slot_nxt = '0;
               end
            end
         end
         S_ISSUE: begin
            if (w_last_hs) begin
               w_pc_nxt = dec_next;
               w_retire = 1'b1;
            end else if (w_hs) begin
               w_slot_nxt = r_slot_idx + LEN_W'(1);
            end
         end
         default: ;
      endcase
      w_retired_nxt = (w_retire && (r_retired != 16'hFFFF)) ? r_retired + 16'd1 : r_retired;
   end

   // Registered outputs; strobes are derived from the upcoming state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= '0;
         r_slot_idx  <= '0;
         r_retired   <= '0;
         r_imem_req  <= 1'b0;
         r_ins_load  <= 1'b0;
         r_alu_issue <= 1'b0;
      end else begin
         r_pc        <= w_pc_nxt;
         r_slot_idx  <= w_slot_nxt;
         r_retired   <= w_retired_nxt;
         r_imem_req  <= (w_state_nxt == S_FETCH);
         r_ins_load  <= (r_state == S_WAIT) && imem_valid;
         r_alu_issue <= (w_state_nxt == S_ISSUE);
      end
   end

   assign imem_req  = r_imem_req;
   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign ins_load  = r_ins_load;
   assign slot_idx  = r_slot_idx;
   assign alu_issue = r_alu_issue;
   assign retired   = r_retired;
   assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
   assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_vliw_sequencer.sv
// Bench for vliw_sequencer: the bench plays instruction memory, decoder and
// ALU. A bundle-level model predicts fetch addresses, retire counts and ALU
// slot handshakes into queues; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_vliw_sequencer;
   localparam int PC_W  = 16;
   localparam int LEN_W = 7;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [PC_W-1:0]  start_pc = '0;
   logic             stop;
   logic             imem_req;
   logic [PC_W-1:0]  imem_addr;
   logic             imem_valid;
   logic             ins_load;
   logic             dec_meta;
   logic [LEN_W-1:0] dec_eval_len;
   logic [PC_W-1:0]  dec_operand;
   logic [PC_W-1:0]  dec_next;
   logic [LEN_W-1:0] slot_idx;
   logic             alu_issue;
   logic             alu_ready;
   logic             busy;
   logic             halted;
   logic [PC_W-1:0]  pc;
   logic [15:0]      retired;

   always #5 clk = ~clk;

   vliw_sequencer #(.PC_W(PC_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .stop(stop),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
      .ins_load(ins_load), .dec_meta(dec_meta), .dec_eval_len(dec_eval_len),
      .dec_operand(dec_operand), .dec_next(dec_next), .slot_idx(slot_idx),
      .alu_issue(alu_issue), .alu_ready(alu_ready), .busy(busy), .halted(halted),
      .pc(pc), .retired(retired)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // program: bundle contents keyed by address
   bit b_meta [int];
   int b_len  [int];
   int b_op   [int];
   int b_nx   [int];
   bit b_stop [int];

   typedef struct { int slot; bit last; } iss_t;
   typedef struct { int addr; int ret; } fet_t;
   iss_t iss_q[$];
   fet_t fet_q[$];

   int mdl_retired = 0;
   bit exp_halt = 0;
   int exp_end_pc = 0;
   int mem_delay = 0;   // 0 selects a random 1..3 cycle latency
   int rdy_mode = 0;    // 0 always ready, 1 random, 2 hold low lowcnt issue cycles
   int lowcnt = 0;

   task automatic clr_prog();
      b_meta.delete(); b_len.delete(); b_op.delete(); b_nx.delete(); b_stop.delete();
   endtask

   task automatic add(input int a, input bit m, input int l, input int op, input int nx, input bit st);
      b_meta[a] = m; b_len[a] = l; b_op[a] = op & 16'hFFFF; b_nx[a] = nx & 16'hFFFF; b_stop[a] = st;
   endtask

   // bundle-level reference model: what this bundle must cause
   task automatic model(input int a);
      bit m; int l; int op; int nx; bit st;
      m  = b_meta.exists(a) ? b_meta[a] : 1'b1;
      l  = b_len.exists(a)  ? b_len[a]  : 0;
      op = b_op.exists(a)   ? b_op[a]   : 0;
      nx = b_nx.exists(a)   ? b_nx[a]   : 0;
      st = b_stop.exists(a) ? b_stop[a] : 1'b0;
      if (st) begin
         exp_halt = 0; exp_end_pc = a;
      end else if (m && l == 0) begin
         exp_halt = 1; exp_end_pc = a;
      end else begin
         if (!m) for (int s = 0; s < l; s++) iss_q.push_back('{slot: s, last: (s == l - 1)});
         if (mdl_retired < 16'hFFFF) mdl_retired++;
         fet_q.push_back('{addr: (m ? op : nx), ret: mdl_retired});
      end
   endtask

   // memory + decoder responder
   initial begin
      imem_valid = 0; dec_meta = 0; dec_eval_len = '0; dec_operand = '0; dec_next = '0; stop = 0;
      forever begin
         @(negedge clk);
         if (rst_n && imem_req) begin
            int a; int d;
            a = int'(imem_addr);
            model(a);
            d = (mem_delay > 0) ? mem_delay : int'($urandom_range(1, 3));
            repeat (d) @(posedge clk);
            #1;
            imem_valid   = 1;
            dec_meta     = b_meta.exists(a) ? b_meta[a] : 1'b1;
            dec_eval_len = b_len.exists(a) ? LEN_W'(b_len[a]) : '0;
            dec_operand  = b_op.exists(a) ? PC_W'(b_op[a]) : '0;
            dec_next     = b_nx.exists(a) ? PC_W'(b_nx[a]) : '0;
            stop         = b_stop.exists(a) ? b_stop[a] : 1'b0;
            @(posedge clk); #1;
            imem_valid = 0;
            @(posedge clk); #1;
            stop = 1'($urandom_range(0, 1));   // junk outside DECODE must be ignored
         end
      end
   end

   // ALU ready driver
   initial begin
      alu_ready = 0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: alu_ready = 1;
            1: alu_ready = 1'($urandom_range(0, 1));
            default: begin
               if (alu_issue && lowcnt > 0) begin
                  alu_ready = 0; lowcnt--;
               end else alu_ready = 1;
            end
         endcase
      end
   end

   // monitor / scoreboard
   bit prev_stall = 0, prev_more = 0, prev_last = 0, prev_valid = 0;
   int prev_slot = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 0; prev_more = 0; prev_last = 0; prev_valid = 0;
         end else begin
            bit hs;
            if (prev_stall) begin
               chk("stall_issue_held", alu_issue, 1);
               chk("stall_slot_held", slot_idx, prev_slot);
            end
            if (prev_more) begin
               chk("next_slot_issue", alu_issue, 1);
               chk("next_slot_idx", slot_idx, prev_slot + 1);
            end
            if (prev_last) chk("issue_drop_after_last", alu_issue, 0);
            chk("ins_load_after_valid", ins_load, prev_valid);
            if (imem_req) begin
               chk("fetch_expected", fet_q.size() != 0, 1);
               if (fet_q.size() != 0) begin
                  fet_t f;
                  f = fet_q.pop_front();
                  chk("fetch_addr", imem_addr, f.addr);
                  chk("retired_at_fetch", retired, f.ret);
               end
            end
            hs = alu_issue && alu_ready;
            prev_more = 0; prev_last = 0;
            if (hs) begin
               chk("issue_expected", iss_q.size() != 0, 1);
               if (iss_q.size() != 0) begin
                  iss_t e;
                  e = iss_q.pop_front();
                  chk("issue_slot", slot_idx, e.slot);
                  prev_more = !e.last;
                  prev_last = e.last;
               end
            end
            prev_stall = alu_issue && !alu_ready;
            prev_slot  = int'(slot_idx);
            prev_valid = imem_valid;
         end
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_imem_req"}, imem_req, 0);
      chk({tag, "_ins_load"}, ins_load, 0);
      chk({tag, "_alu_issue"}, alu_issue, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_halted"}, halted, 0);
      chk({tag, "_pc"}, pc, 0);
      chk({tag, "_slot_idx"}, slot_idx, 0);
      chk({tag, "_retired"}, retired, 0);
   endtask

   task automatic do_reset();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      iss_q.delete(); fet_q.delete(); mdl_retired = 0; exp_halt = 0;
      rst_n = 1;
   endtask

   task automatic run(input int spc, input bit do_rst);
      int k;
      if (do_rst) do_reset();
      @(posedge clk); #1;
      start = 1; start_pc = PC_W'(spc);
      fet_q.push_back('{addr: spc & 16'hFFFF, ret: mdl_retired});
      @(posedge clk); #1;
      start = 0;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("run_completes", k < 3000, 1);
      repeat (2) @(negedge clk);
      chk("end_halted", halted, exp_halt);
      chk("end_pc", pc, exp_end_pc);
      chk("end_retired", retired, mdl_retired);
      chk("fetch_queue_drained", fet_q.size(), 0);
      chk("issue_queue_drained", iss_q.size(), 0);
   endtask

   task automatic build_rand(output int spc);
      int a; int n; int nx;
      clr_prog();
      a = int'($urandom_range(0, 65535));
      spc = a;
      n = int'($urandom_range(2, 8));
      for (int i = 0; i < n; i++) begin
         nx = int'($urandom_range(0, 65535));
         while (nx == a || b_len.exists(nx)) nx = int'($urandom_range(0, 65535));
         case ($urandom_range(0, 2))
            0: add(a, 1, int'($urandom_range(1, 127)), nx, int'($urandom_range(0, 65535)), 0);
            1: add(a, 0, 0, int'($urandom_range(0, 65535)), nx, 0);
            default: add(a, 0, int'($urandom_range(1, 12)), int'($urandom_range(0, 65535)), nx, 0);
         endcase
         a = nx;
      end
      if ($urandom_range(0, 3) == 0)
         add(a, 0, int'($urandom_range(0, 6)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1);
      else
         add(a, 1, 0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors so far", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      int spc; int k; bit last_halt;

      // basic 3-slot bundle, memory latency 2, then halt
      clr_prog();
      add(16'h0010, 0, 3, 0, 16'h0011, 0);
      add(16'h0011, 1, 0, 0, 0, 0);
      mem_delay = 2; rdy_mode = 0;
      run(16'h0010, 1);

      // start while halted is ignored; reset leaves HALT
      @(posedge clk); #1; start = 1; start_pc = 16'h0055;
      @(posedge clk); #1; start = 0;
      repeat (5) @(negedge clk);
      chk("halt_start_ignored_halted", halted, 1);
      chk("halt_start_ignored_busy", busy, 0);
      chk("halt_start_ignored_pc", pc, 16'h0011);
      do_reset();

      // ALU backpressure on slot 0
      clr_prog();
      add(16'h0020, 0, 2, 0, 16'h0021, 0);
      add(16'h0021, 1, 0, 0, 0, 0);
      mem_delay = 0; rdy_mode = 2; lowcnt = 4;
      run(16'h0020, 1);
      chk("backpressure_cycles_seen", lowcnt, 0);

      // meta jump: no slots issued, next fetch from operand
      clr_prog();
      add(16'h0100, 1, 5, 16'h0200, 16'h0101, 0);
      add(16'h0200, 1, 0, 0, 0, 0);
      rdy_mode = 0;
      run(16'h0100, 1);

      // stop in DECODE: back to IDLE with pc on the un-executed bundle,
      // then a fresh start runs an empty bundle into a halt
      clr_prog();
      add(16'h0300, 0, 4, 0, 16'h0301, 1);
      rdy_mode = 1;
      run(16'h0300, 1);
      add(16'h0400, 0, 0, 0, 16'h0401, 0);
      add(16'h0401, 1, 0, 0, 0, 0);
      run(16'h0400, 0);

      // pc wrap
      clr_prog();
      add(16'hFFFF, 0, 1, 0, 16'h0000, 0);
      add(16'h0000, 1, 0, 0, 0, 0);
      run(16'hFFFF, 1);

      // reset while issuing slot 1
      clr_prog();
      add(16'h0500, 0, 4, 0, 16'h0501, 0);
      add(16'h0501, 1, 0, 0, 0, 0);
      rdy_mode = 0;
      do_reset();
      @(posedge clk); #1; start = 1; start_pc = 16'h0500;
      fet_q.push_back('{addr: 16'h0500, ret: 0});
      @(posedge clk); #1; start = 0;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (alu_issue && slot_idx == 1) break;
      end
      chk("reach_slot1", k < 200, 1);
      rst_n = 0;
      #1;
      chk_reset_vals("midissue");
      iss_q.delete(); fet_q.delete(); mdl_retired = 0;
      clr_prog();
      add(16'h0600, 0, 2, 0, 16'h0601, 0);
      add(16'h0601, 1, 0, 0, 0, 0);
      run(16'h0600, 1);

      // randomized programs with random memory latency and ALU readiness
      rdy_mode = 1; mem_delay = 0; last_halt = 1;
      for (int t = 0; t < 25; t++) begin
         build_rand(spc);
         run(spc, last_halt || ($urandom_range(0, 1) == 1));
         last_halt = exp_halt;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
